// File: rtl/gpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gpu_ctrl_pkg
// Shared definitions for the GPU control sequencer: AXI4-Lite response codes
// and the sequencer state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package gpu_ctrl_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4,
        ST_RSP          = 3'd5
    } seq_state_e;

endpackage

// File: rtl/gpu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// gpu_ctrl_sequencer
// Single-outstanding AXI4-Lite master. Accepts one register read/write command
// at a time, runs it as a legal AXI4-Lite transaction on m_axi_ctrl_*, and
// returns read data plus the raw BRESP/RRESP on the response stream.
//
// Ports:
//   s_axi_ctrl_aclk / s_axi_ctrl_aresetn : clock, async active-low reset
//   cmd_*        : command stream in (valid/ready, we, addr, wdata)
//   rsp_*        : response stream out (valid/ready, rdata, err)
//   m_axi_ctrl_* : AXI4-Lite master (AW, W, B, AR, R channels)
//
// Optional feature (macro GPU_CTRL_SEQ_ERR_STICKY_EN):
//   err_sticky (out) : set on any captured response other than OKAY
//   err_clear  (in)  : clears err_sticky; a same-cycle set takes priority
// -----------------------------------------------------------------------------
module gpu_ctrl_sequencer
    import gpu_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     s_axi_ctrl_aclk,
    input  logic                     s_axi_ctrl_aresetn,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_err,

    output logic [ADDRESS_WIDTH-1:0] m_axi_ctrl_awaddr,
    output logic                     m_axi_ctrl_awvalid,
    input  logic                     m_axi_ctrl_awready,
    output logic [DATA_WIDTH-1:0]    m_axi_ctrl_wdata,
    output logic                     m_axi_ctrl_wvalid,
    input  logic                     m_axi_ctrl_wready,
    input  logic [1:0]               m_axi_ctrl_bresp,
    input  logic                     m_axi_ctrl_bvalid,
    output logic                     m_axi_ctrl_bready,
    output logic [ADDRESS_WIDTH-1:0] m_axi_ctrl_araddr,
    output logic                     m_axi_ctrl_arvalid,
    input  logic                     m_axi_ctrl_arready,
    input  logic [DATA_WIDTH-1:0]    m_axi_ctrl_rdata,
    input  logic [1:0]               m_axi_ctrl_rresp,
    input  logic                     m_axi_ctrl_rvalid,
    output logic                     m_axi_ctrl_rready
`ifdef GPU_CTRL_SEQ_ERR_STICKY_EN
    ,
    output logic                     err_sticky,
    input  logic                     err_clear
`endif
);

    seq_state_e               state_q,     state_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic [ADDRESS_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q,     wdata_d;
    logic                     awvalid_q,   awvalid_d;
    logic                     wvalid_q,    wvalid_d;
    logic                     bready_q,    bready_d;
    logic                     arvalid_q,   arvalid_d;
    logic                     rready_q,    rready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]               rsp_err_q,   rsp_err_d;

    // Next-state logic. Every AXI valid/ready is a flop, so no valid ever
    // depends combinationally on a ready. The latched address/data drive the
    // channels, which keeps them stable for as long as valid is high.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready is 0 out of reset and rises on the first clock.
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    cmd_ready_d = 1'b0;
                    if (cmd_we) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end

            ST_WR_ADDR_DATA: begin
                // AW and W complete independently; move on once both are done.
                if (awvalid_q && m_axi_ctrl_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axi_ctrl_wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end

            ST_WR_RESP: begin
                if (m_axi_ctrl_bvalid) begin
                    rsp_err_d   = m_axi_ctrl_bresp;
                    rsp_rdata_d = '0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end

            ST_RD_ADDR: begin
                if (m_axi_ctrl_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end

            ST_RD_DATA: begin
                if (m_axi_ctrl_rvalid) begin
                    rsp_rdata_d = m_axi_ctrl_rdata;
                    rsp_err_d   = m_axi_ctrl_rresp;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end

            ST_RSP: begin
                // No response buffering: new commands wait for this handshake.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight command silently.
    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef GPU_CTRL_SEQ_ERR_STICKY_EN
    logic err_sticky_q, err_sticky_d;
    logic err_capture;

    // A non-OKAY response captured this cycle sets the flag, beating a clear.
    always_comb begin
        err_capture = ((state_q == ST_WR_RESP) && m_axi_ctrl_bvalid &&
                       (m_axi_ctrl_bresp != RESP_OKAY)) ||
                      ((state_q == ST_RD_DATA) && m_axi_ctrl_rvalid &&
                       (m_axi_ctrl_rresp != RESP_OKAY));
        err_sticky_d = err_sticky_q;
        if (err_capture) begin
            err_sticky_d = 1'b1;
        end else if (err_clear) begin
            err_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge s_axi_ctrl_aclk or negedge s_axi_ctrl_aresetn) begin
        if (!s_axi_ctrl_aresetn) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

    assign cmd_ready          = cmd_ready_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign rsp_err            = rsp_err_q;
    assign m_axi_ctrl_awaddr  = addr_q;
    assign m_axi_ctrl_awvalid = awvalid_q;
    assign m_axi_ctrl_wdata   = wdata_q;
    assign m_axi_ctrl_wvalid  = wvalid_q;
    assign m_axi_ctrl_bready  = bready_q;
    assign m_axi_ctrl_araddr  = addr_q;
    assign m_axi_ctrl_arvalid = arvalid_q;
    assign m_axi_ctrl_rready  = rready_q;

endmodule

// File: tb/tb_gpu_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gpu_ctrl_sequencer
// Directed bench for gpu_ctrl_sequencer with a delay-configurable AXI4-Lite
// slave model and a response scoreboard. Honours GPU_CTRL_SEQ_ERR_STICKY_EN.
// -----------------------------------------------------------------------------
module tb_gpu_ctrl_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;
`ifdef GPU_CTRL_SEQ_ERR_STICKY_EN
    logic        err_sticky;
    logic        err_clear;
`endif

    int checks   = 0;
    int failures = 0;
    int rsp_seen = 0;

    // Slave timing/data configuration, set by the directed steps.
    int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    logic [31:0] exp_rdata_q[$];
    logic [1:0]  exp_err_q[$];

    gpu_ctrl_sequencer #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .s_axi_ctrl_aclk    (clk),
        .s_axi_ctrl_aresetn (rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_we             (cmd_we),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .m_axi_ctrl_awaddr  (awaddr),
        .m_axi_ctrl_awvalid (awvalid),
        .m_axi_ctrl_awready (awready),
        .m_axi_ctrl_wdata   (wdata),
        .m_axi_ctrl_wvalid  (wvalid),
        .m_axi_ctrl_wready  (wready),
        .m_axi_ctrl_bresp   (bresp),
        .m_axi_ctrl_bvalid  (bvalid),
        .m_axi_ctrl_bready  (bready),
        .m_axi_ctrl_araddr  (araddr),
        .m_axi_ctrl_arvalid (arvalid),
        .m_axi_ctrl_arready (arready),
        .m_axi_ctrl_rdata   (rdata),
        .m_axi_ctrl_rresp   (rresp),
        .m_axi_ctrl_rvalid  (rvalid),
        .m_axi_ctrl_rready  (rready)
`ifdef GPU_CTRL_SEQ_ERR_STICKY_EN
        ,
        .err_sticky         (err_sticky),
        .err_clear          (err_clear)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: each ready rises once its channel has waited <delay> cycles;
    // B/R valid rise <delay> cycles after the request side has completed.
    int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic aw_done, w_done, ar_done;

    assign awready = awvalid && (aw_cnt >= aw_delay);
    assign wready  = wvalid  && (w_cnt  >= w_delay);
    assign arready = arvalid && (ar_cnt >= ar_delay);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_done <= 1'b0; w_done <= 1'b0; ar_done <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
        end else begin
            if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
            if (awvalid && awready) begin aw_cnt <= 0; aw_done <= 1'b1; end
            if (wvalid && !wready) w_cnt <= w_cnt + 1;
            if (wvalid && wready) begin w_cnt <= 0; w_done <= 1'b1; end
            if ((aw_done || (awvalid && awready)) && (w_done || (wvalid && wready)) && !bvalid) begin
                if (b_cnt >= b_delay) begin
                    bvalid <= 1'b1;
                    bresp  <= cfg_bresp;
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_done <= 1'b0; w_done <= 1'b0; b_cnt <= 0;
            end
            if (arvalid && !arready) ar_cnt <= ar_cnt + 1;
            if (arvalid && arready) begin ar_cnt <= 0; ar_done <= 1'b1; end
            if ((ar_done || (arvalid && arready)) && !rvalid) begin
                if (r_cnt >= r_delay) begin
                    rvalid <= 1'b1;
                    rresp  <= cfg_rresp;
                    rdata  <= cfg_rdata;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; ar_done <= 1'b0; r_cnt <= 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Scoreboard: pop and compare on every response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_seen++;
            if (exp_rdata_q.size() == 0) begin
                checkOutput("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                checkOutput("sb_rdata", rsp_rdata, exp_rdata_q.pop_front());
                checkOutput("sb_err", {30'd0, rsp_err}, {30'd0, exp_err_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] exp_rdata,
                                 input logic [1:0] exp_err);
        int n;
        n = 0;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) checkOutput("cmd_ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = data;
        exp_rdata_q.push_back(exp_rdata);
        exp_err_q.push_back(exp_err);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
        if (!rsp_valid) checkOutput(tag, 32'd0, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
        cmd_addr = 32'h0; cmd_wdata = 32'h0; rsp_ready = 1'b1;
`ifdef GPU_CTRL_SEQ_ERR_STICKY_EN
        err_clear = 1'b0;
`endif
        tick(); tick();
        // Reset state.
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("rst_valids", {28'd0, awvalid, wvalid, arvalid, rsp_valid}, 32'd0);
        checkOutput("rst_readies", {30'd0, bready, rready}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        checkOutput("first_clk_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // Zero-wait write: AW/W at N+1, B at N+2, response at N+3.
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 2'b00);
        checkOutput("wr0_awvalid", {31'd0, awvalid}, 32'd1);
        checkOutput("wr0_wvalid", {31'd0, wvalid}, 32'd1);
        checkOutput("wr0_awaddr", awaddr, 32'h10);
        checkOutput("wr0_wdata", wdata, 32'hDEADBEEF);
        checkOutput("wr0_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        checkOutput("wr0_aw_w_dropped", {30'd0, awvalid, wvalid}, 32'd0);
        checkOutput("wr0_bready", {31'd0, bready}, 32'd1);
        tick();
        checkOutput("wr0_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("wr0_bready_low", {31'd0, bready}, 32'd0);
        tick();
        checkOutput("wr0_rsp_done", {31'd0, rsp_valid}, 32'd0);
        checkOutput("wr0_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

        // Write with W accepted 3 cycles after AW.
        w_delay = 3;
        applyStimulus(1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 2'b00);
        tick();
        checkOutput("wr1_awvalid_dropped", {31'd0, awvalid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("wr1_wvalid_held", {31'd0, wvalid}, 32'd1);
            checkOutput("wr1_wdata_stable", wdata, 32'hCAFEF00D);
            tick();
        end
        checkOutput("wr1_wvalid_dropped", {31'd0, wvalid}, 32'd0);
        waitRsp("wr1_rsp_timeout");
        tick();
        checkOutput("wr1_single_rsp", {31'd0, rsp_valid}, 32'd0);
        w_delay = 0;

        // Read with a 1-cycle AR wait and 2-cycle R delay.
        ar_delay = 1; r_delay = 2; cfg_rdata = 32'h12345678; cfg_rresp = 2'b00;
        applyStimulus(1'b0, 32'h04, 32'h0, 32'h12345678, 2'b00);
        checkOutput("rd0_araddr", araddr, 32'h04);
        checkOutput("rd0_arvalid_0", {31'd0, arvalid}, 32'd1);
        tick();
        checkOutput("rd0_arvalid_1", {31'd0, arvalid}, 32'd1);
        tick();
        checkOutput("rd0_arvalid_dropped", {31'd0, arvalid}, 32'd0);
        checkOutput("rd0_rready", {31'd0, rready}, 32'd1);
        waitRsp("rd0_rsp_timeout");
        tick();
        ar_delay = 0; r_delay = 0;

        // SLVERR read held by rsp_ready=0 for 4 cycles.
        cfg_rresp = 2'b10; cfg_rdata = 32'hA5A5A5A5;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 32'h08, 32'h0, 32'hA5A5A5A5, 2'b10);
        waitRsp("rd1_rsp_timeout");
        for (int i = 0; i < 4; i++) begin
            checkOutput("rd1_rsp_held", {31'd0, rsp_valid}, 32'd1);
            checkOutput("rd1_err_stable", {30'd0, rsp_err}, 32'd2);
            checkOutput("rd1_cmd_blocked", {31'd0, cmd_ready}, 32'd0);
            tick();
        end
`ifdef GPU_CTRL_SEQ_ERR_STICKY_EN
        checkOutput("sticky_set", {31'd0, err_sticky}, 32'd1);
`endif
        rsp_ready = 1'b1;
        tick();
        checkOutput("rd1_rsp_done", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rd1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
`ifdef GPU_CTRL_SEQ_ERR_STICKY_EN
        checkOutput("sticky_kept", {31'd0, err_sticky}, 32'd1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checkOutput("sticky_cleared", {31'd0, err_sticky}, 32'd0);
`endif
        cfg_rresp = 2'b00;

        // Reset while waiting for B: command dropped, no response.
        b_delay = 5;
        applyStimulus(1'b1, 32'h30, 32'h11112222, 32'h0, 2'b00);
        tick(); tick();
        checkOutput("rst_mid_bready_before", {31'd0, bready}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valids", {28'd0, awvalid, wvalid, arvalid, rsp_valid}, 32'd0);
        checkOutput("rst_mid_readies", {29'd0, bready, rready, cmd_ready}, 32'd0);
        exp_rdata_q.delete();
        exp_err_q.delete();
        b_delay = 0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checkOutput("rst_mid_rel_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        tick();
        checkOutput("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rst_mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
            tick();
        end

        checkOutput("sb_empty", exp_rdata_q.size(), 32'd0);
        checkOutput("rsp_count", rsp_seen, 32'd4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
